seg_counter_mux: RTL and testbench
==================================

# seg_counter_mux

Parametrised N-digit BCD up/down counter with a multiplexed seven-segment display driver. It generalises the fixed 4-digit up-only counter to any digit count, adds direction, enable, parallel load and carry/borrow status, and exposes the count value. It runs entirely in the board clock domain and uses internal prescalers instead of a derived clock. It sits between the board clock/reset and the seven-segment anode/cathode pins.

## Interface
- DIGITS, 4: number of BCD digits, ≥1.
- COUNT_DIV, 50_000_000: clk cycles per count step, ≥2.
- SCAN_DIV, 65_536: clk cycles each digit stays lit, ≥1.
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  1 = prescaler runs; 0 = prescaler and count frozen. Scan always runs.
- up  in  1  1 = count up, 0 = count down; sampled at each tick.
- load  in  1  1 = load load_val into the count on this edge.
- load_val  in  4*DIGITS  BCD load value; digit i is bits [4i+3:4i].
- count  out  4*DIGITS  current BCD count; digit 0 is least significant.
- digit  out  DIGITS  one-hot active-high digit enable; bit i lights BCD digit i.
- seg  out  8  active-low cathodes {a,b,c,d,e,f,g,dp}; dp is always 1.
- tick  out  1  one-cycle pulse on each count step.
- wrap  out  1  one-cycle pulse when the count wraps (carry-out or borrow-out).

## Operation
- Prescaler width: $clog2(COUNT_DIV).
  - Increments while en=1.
  - At value COUNT_DIV-1 it returns to 0 and a step occurs.
- Step, up=1: BCD ripple increment. A digit at 9 becomes 0 and carries into the next digit. All-9s becomes all-0s and wrap=1.
- Step, up=0: BCD ripple decrement. A digit at 0 becomes 9 and borrows from the next digit. All-0s becomes all-9s and wrap=1.
- Load:
  - Has priority over a step in the same cycle.
  - Clears the prescaler to 0.
  - Suppresses tick and wrap for that cycle.
  - Any load_val digit >9 is stored as 0.
- Scan:
  - Slot counter width $clog2(SCAN_DIV); free-running, independent of en and load.
  - Every SCAN_DIV cycles the active digit moves down one: DIGITS-1 → DIGITS-2 → … → 0, then back to DIGITS-1.
- Decoder (active-low):
  - 0=00000011, 1=10011111, 2=00100101, 3=00001101, 4=10011001
  - 5=01001001, 6=01000001, 7=00011111, 8=00000001, 9=00001001
  - any other value=11111111.
- Reset values:
  - count=0, digit bit DIGITS-1 set (only that bit), seg=00000011.
  - tick=0, wrap=0, prescaler=0, slot counter=0.

## Timing
- count, tick and wrap are registered and change on the same edge: the edge where the prescaler leaves COUNT_DIV-1.
- Step period with en held high: exactly COUNT_DIV cycles. The first step after reset or load comes COUNT_DIV cycles later.
- en deasserted mid-period holds the prescaler value. The remaining cycles complete after en re-asserts.
- Load: count = load_val one cycle after the load edge.
- up changes take effect at the next step only.
- digit and seg are registered together; seg always matches the digit currently lit.
  - seg follows a count change on the cycle after count updates.
  - digit advances on the edge where the slot counter leaves SCAN_DIV-1.
- rst asserted at any time: every register takes its reset value on the next edge, overriding load and step.

## Configuration
- SEG_LZB_EN defined: leading-zero blanking.
  - A digit i>0 is blanked (seg=11111111) when it and every digit above it are 0.
  - Digit 0 is never blanked.
  - This affects seg only; count, digit and scan timing are unchanged.
- SEG_LZB_EN undefined: every digit is decoded, including leading zeros.

## Test plan
All scenarios use DIGITS=4, COUNT_DIV=4, SCAN_DIV=2.
- Reset, then en=1, up=1 → count=0x0000, digit=1000, seg=00000011. After 4 cycles: tick pulses once, count=0x0001, wrap=0.
- Load 0x9998, up=1, then 2 steps → count 0x9999 (wrap=0), then 0x0000 with wrap=1 for exactly one cycle.
- Load 0x0001, up=0, then 2 steps → count 0x0000, then 0x9999 with wrap=1 for one cycle.
- Load 0x12A4 asserted on the same cycle a step is due → count=0x1204, tick=0. The next tick arrives 4 cycles later.
- count=0x1234, en=0, 8 cycles:
  - digit sequence 1000, 0100, 0010, 0001, 2 cycles each;
  - matching seg 10011111, 00100101, 00001101, 10011001;
  - count stays frozen.
- count=0x0007:
  - With SEG_LZB_EN: digits 3–1 give seg=11111111; digit 0 gives 00011111.
  - Without SEG_LZB_EN: digits 3–1 give 00000011.
  - rst pulsed mid-scan in either build: all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/seg_counter_mux.sv
// rtl/seg_counter_mux.sv - N-digit BCD up/down counter with multiplexed seven-segment driver
// Optional leading-zero blanking with `define SEG_LZB_EN.
module seg_counter_mux #(
  parameter int DIGITS    = 4,
  parameter int COUNT_DIV = 50_000_000,
  parameter int SCAN_DIV  = 65_536
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic [DIGITS-1:0]     digit,
  output logic [7:0]            seg,
  output logic                  tick,
  output logic                  wrap
);

  localparam int PW   = $clog2(COUNT_DIV);
  localparam int SW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int SELW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0]   PRE_LAST  = PW'(COUNT_DIV - 1);
  localparam logic [SW-1:0]   SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [SELW-1:0] SEL_TOP   = SELW'(DIGITS - 1);

  function automatic logic [7:0] seg_decode(input logic [3:0] v);
    case (v)
      4'd0:    seg_decode = 8'b00000011;
      4'd1:    seg_decode = 8'b10011111;
      4'd2:    seg_decode = 8'b00100101;
      4'd3:    seg_decode = 8'b00001101;
      4'd4:    seg_decode = 8'b10011001;
      4'd5:    seg_decode = 8'b01001001;
      4'd6:    seg_decode = 8'b01000001;
      4'd7:    seg_decode = 8'b00011111;
      4'd8:    seg_decode = 8'b00000001;
      4'd9:    seg_decode = 8'b00001001;
      default: seg_decode = 8'b11111111;
    endcase
  endfunction

  logic [PW-1:0]       pre;
  logic [SW-1:0]       slot;
  logic [SELW-1:0]     sel;
  logic                step;
  logic [4*DIGITS-1:0] inc_val, dec_val, load_clean;
  logic                carry, borrow;
  logic [SELW-1:0]     sel_next;
  logic [DIGITS-1:0]   digit_next;
  logic [3:0]          cur_bcd;
  logic                blank;

  assign step = en && (pre == PRE_LAST);

  // Ripple carry/borrow: carry/borrow survive the loop only when every digit was 9 / 0.
  always_comb begin
    inc_val    = count;
    dec_val    = count;
    load_clean = '0;
    carry      = 1'b1;
    borrow     = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (count[4*i +: 4] == 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = count[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (count[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = count[4*i +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
      load_clean[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd0 : load_val[4*i +: 4];
    end
  end

  // seg is computed for the digit about to be lit so the two registers stay paired.
  always_comb begin
    sel_next = sel;
    if (slot == SLOT_LAST) begin
      sel_next = (sel == '0) ? SEL_TOP : sel - 1'b1;
    end
    digit_next = '0;
    digit_next[sel_next] = 1'b1;
    cur_bcd = count[4*int'(sel_next) +: 4];
  end

`ifdef SEG_LZB_EN
  logic [DIGITS-1:0] zero_run;
  logic              run;

  always_comb begin
    zero_run = '0;
    run      = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      run         = run && (count[4*i +: 4] == 4'd0);
      zero_run[i] = run;
    end
    blank = zero_run[sel_next] && (sel_next != '0);
  end
`else
  assign blank = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pre   <= '0;
      count <= '0;
      tick  <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      tick <= 1'b0;
      wrap <= 1'b0;
      if (load) begin
        pre   <= '0;
        count <= load_clean;
      end else if (en) begin
        if (step) begin
          pre   <= '0;
          tick  <= 1'b1;
          count <= up ? inc_val : dec_val;
          wrap  <= up ? carry : borrow;
        end else begin
          pre <= pre + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot  <= '0;
      sel   <= SEL_TOP;
      digit <= DIGITS'(1) << (DIGITS - 1);
      seg   <= 8'b00000011;
    end else begin
      slot  <= (slot == SLOT_LAST) ? '0 : slot + 1'b1;
      sel   <= sel_next;
      digit <= digit_next;
      seg   <= blank ? 8'b11111111 : seg_decode(cur_bcd);
    end
  end

endmodule

// File: tb/tb_seg_counter_mux.sv
// tb/tb_seg_counter_mux.sv - directed self-checking bench for seg_counter_mux
// Honours SEG_LZB_EN when compiled with it.
module tb_seg_counter_mux;

  logic        clk = 1'b0;
  logic        rst, en, up, load;
  logic [15:0] load_val;
  logic [15:0] count;
  logic [3:0]  digit;
  logic [7:0]  seg;
  logic        tick, wrap;

  int errors = 0;
  int checks = 0;

  seg_counter_mux #(.DIGITS(4), .COUNT_DIV(4), .SCAN_DIV(2)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(count), .digit(digit), .seg(seg), .tick(tick), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1'b1;
    load_val = v;
    cyc();
    load = 1'b0;
  endtask

  // Leaves the bench on the first cycle digit 3 is lit.
  task automatic align_scan(input string name);
    int n;
    n = 0;
    while (digit !== 4'b0001 && n < 20) begin cyc(); n++; end
    while (digit !== 4'b1000 && n < 20) begin cyc(); n++; end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL %s align: digit=%b never cycled to 1000", name, digit);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;
    cyc(); cyc();
    checks++; if (count !== 16'h0000) begin errors++; $display("FAIL reset_count got=%h exp=0000", count); end
    checks++; if (digit !== 4'b1000) begin errors++; $display("FAIL reset_digit got=%b exp=1000", digit); end
    checks++; if (seg !== 8'b00000011) begin errors++; $display("FAIL reset_seg got=%b exp=00000011", seg); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick got=%b exp=0", tick); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got=%b exp=0", wrap); end
    rst = 1'b0; en = 1'b1;
  endtask

  task automatic test_count_up();
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++; if (tick !== 1'b0) begin errors++; $display("FAIL up_early_tick%0d got=%b exp=0", i, tick); end
    end
    cyc();
    checks++; if (tick !== 1'b1) begin errors++; $display("FAIL up_tick got=%b exp=1", tick); end
    checks++; if (count !== 16'h0001) begin errors++; $display("FAIL up_count got=%h exp=0001", count); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL up_wrap got=%b exp=0", wrap); end
    cyc();
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL up_tick_width got=%b exp=0", tick); end
  endtask

  task automatic test_wrap_up();
    up = 1'b1;
    do_load(16'h9998);
    checks++; if (count !== 16'h9998) begin errors++; $display("FAIL wup_load got=%h exp=9998", count); end
    repeat (4) cyc();
    checks++; if (count !== 16'h9999 || wrap !== 1'b0) begin errors++; $display("FAIL wup_step1 count=%h wrap=%b exp=9999/0", count, wrap); end
    repeat (4) cyc();
    checks++; if (count !== 16'h0000 || wrap !== 1'b1) begin errors++; $display("FAIL wup_step2 count=%h wrap=%b exp=0000/1", count, wrap); end
    cyc();
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL wup_wrap_width got=%b exp=0", wrap); end
  endtask

  task automatic test_wrap_down();
    up = 1'b0;
    do_load(16'h0001);
    repeat (4) cyc();
    checks++; if (count !== 16'h0000 || wrap !== 1'b0) begin errors++; $display("FAIL wdn_step1 count=%h wrap=%b exp=0000/0", count, wrap); end
    repeat (4) cyc();
    checks++; if (count !== 16'h9999 || wrap !== 1'b1) begin errors++; $display("FAIL wdn_step2 count=%h wrap=%b exp=9999/1", count, wrap); end
    cyc();
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL wdn_wrap_width got=%b exp=0", wrap); end
    up = 1'b1;
  endtask

  task automatic test_load_on_step();
    do_load(16'h0000);
    repeat (3) cyc();
    load = 1'b1; load_val = 16'h12A4;
    cyc();
    load = 1'b0;
    checks++; if (count !== 16'h1204) begin errors++; $display("FAIL ls_count got=%h exp=1204", count); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL ls_tick got=%b exp=0", tick); end
    repeat (3) cyc();
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL ls_early got=%b exp=0", tick); end
    cyc();
    checks++; if (tick !== 1'b1 || count !== 16'h1205) begin errors++; $display("FAIL ls_next tick=%b count=%h exp=1/1205", tick, count); end
  endtask

  task automatic test_en_hold();
    do_load(16'h0000);
    repeat (2) cyc();
    en = 1'b0;
    repeat (5) cyc();
    checks++; if (tick !== 1'b0 || count !== 16'h0000) begin errors++; $display("FAIL hold_frozen tick=%b count=%h exp=0/0000", tick, count); end
    en = 1'b1;
    cyc();
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL hold_resume_early got=%b exp=0", tick); end
    cyc();
    checks++; if (tick !== 1'b1 || count !== 16'h0001) begin errors++; $display("FAIL hold_resume tick=%b count=%h exp=1/0001", tick, count); end
  endtask

  task automatic test_scan();
    logic [7:0] exp_seg [4];
    exp_seg[3] = 8'b10011111; exp_seg[2] = 8'b00100101;
    exp_seg[1] = 8'b00001101; exp_seg[0] = 8'b10011001;
    en = 1'b0;
    do_load(16'h1234);
    align_scan("scan");
    for (int k = 0; k < 8; k++) begin
      int d;
      d = 3 - k / 2;
      checks++; if (digit !== (4'b0001 << d)) begin errors++; $display("FAIL scan_digit%0d got=%b exp_idx=%0d", k, digit, d); end
      checks++; if (seg !== exp_seg[d]) begin errors++; $display("FAIL scan_seg%0d got=%b exp=%b", k, seg, exp_seg[d]); end
      cyc();
    end
    checks++; if (count !== 16'h1234) begin errors++; $display("FAIL scan_frozen got=%h exp=1234", count); end
  endtask

  task automatic test_lzb();
    logic [7:0] lead;
`ifdef SEG_LZB_EN
    lead = 8'b11111111;
`else
    lead = 8'b00000011;
`endif
    do_load(16'h0007);
    align_scan("lzb");
    for (int d = 3; d >= 0; d--) begin
      checks++;
      if (d > 0) begin
        if (seg !== lead) begin errors++; $display("FAIL lzb_seg%0d got=%b exp=%b", d, seg, lead); end
      end else begin
        if (seg !== 8'b00011111) begin errors++; $display("FAIL lzb_seg0 got=%b exp=00011111", seg); end
      end
      cyc(); cyc();
    end
  endtask

  task automatic test_reset_mid();
    en = 1'b1;
    do_load(16'h0042);
    cyc();
    rst = 1'b1; load = 1'b1; load_val = 16'h5555;
    cyc();
    checks++; if (count !== 16'h0000) begin errors++; $display("FAIL rmid_count got=%h exp=0000", count); end
    checks++; if (digit !== 4'b1000) begin errors++; $display("FAIL rmid_digit got=%b exp=1000", digit); end
    checks++; if (seg !== 8'b00000011) begin errors++; $display("FAIL rmid_seg got=%b exp=00000011", seg); end
    checks++; if (tick !== 1'b0 || wrap !== 1'b0) begin errors++; $display("FAIL rmid_pulses tick=%b wrap=%b exp=0/0", tick, wrap); end
    rst = 1'b0; load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_wrap_up();
    test_wrap_down();
    test_load_on_step();
    test_en_hold();
    test_scan();
    test_lzb();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
